// File: rtl/poly_sequencer_if.sv
// poly_sequencer_if: command, breaker and rasterizer signals of the quad-splitting
// sequencer, bundled in one interface.
//   slave  : sequencer side (accepts commands, drives breaker inputs, offers triangles)
//   master : environment side (upstream command source, breaker, rasterizer)
// Ports (sequencer view):
//   in_valid/in_ready/in_is_quad/in_x/in_y : primitive command handshake
//   brk_x/brk_y (out), brk_t0_*/brk_t1_* (in) : quad breaker connection
//   tri_valid/tri_ready/tri_x/tri_y/tri_last : triangle handshake to rasterizer
//   tri_count (out) : triangles delivered since reset
interface poly_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_quad;
    logic [63:0] in_x;
    logic [63:0] in_y;

    logic [63:0] brk_x;
    logic [63:0] brk_y;
    logic [47:0] brk_t0_x;
    logic [47:0] brk_t0_y;
    logic [47:0] brk_t1_x;
    logic [47:0] brk_t1_y;

    logic        tri_valid;
    logic        tri_ready;
    logic [47:0] tri_x;
    logic [47:0] tri_y;
    logic        tri_last;
    logic [15:0] tri_count;

    modport slave (
        input  in_valid, in_is_quad, in_x, in_y,
        output in_ready,
        output brk_x, brk_y,
        input  brk_t0_x, brk_t0_y, brk_t1_x, brk_t1_y,
        output tri_valid, tri_x, tri_y, tri_last, tri_count,
        input  tri_ready
    );

    modport master (
        output in_valid, in_is_quad, in_x, in_y,
        input  in_ready,
        input  brk_x, brk_y,
        output brk_t0_x, brk_t0_y, brk_t1_x, brk_t1_y,
        input  tri_valid, tri_x, tri_y, tri_last, tri_count,
        output tri_ready
    );
endinterface

// File: rtl/poly_sequencer.sv
// poly_sequencer: accepts one triangle/quad command at a time, lets the external
// quad breaker settle for BREAK_LAT extra cycles, then issues the resulting
// triangles one by one to the rasterizer, flagging the last one of each primitive.
// Ports:
//   clk   : system clock
//   rst_l : asynchronous active-low reset
//   bus   : poly_sequencer_if.slave (command, breaker and triangle signals)
module poly_sequencer #(
    parameter int unsigned BREAK_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_l,
    poly_sequencer_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VTX_W  = 64;
    localparam int unsigned TRI_W  = 48;
    localparam int unsigned TCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        EMIT0 = 2'd2,
        EMIT1 = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    settle_q;
    logic [VTX_W-1:0]    vtx_x_q;
    logic [VTX_W-1:0]    vtx_y_q;
    logic [TRI_W-1:0]    tri0_x_q;
    logic [TRI_W-1:0]    tri0_y_q;
    logic [TRI_W-1:0]    tri1_x_q;
    logic [TRI_W-1:0]    tri1_y_q;
    logic [TCNT_W-1:0]   count_q;

    logic accept_c;
    logic capture_c;
    logic dec_c;
    logic hs_c;

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath enables
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        dec_c     = 1'b0;
        hs_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = bus.in_is_quad ? BREAK : EMIT1;
                end
            end
            BREAK: begin
                if (settle_q == '0) begin
                    capture_c = 1'b1;
                    state_d   = EMIT0;
                end else begin
                    dec_c = 1'b1;
                end
            end
            EMIT0: begin
                if (bus.tri_ready) begin
                    hs_c    = 1'b1;
                    state_d = EMIT1;
                end
            end
            EMIT1: begin
                if (bus.tri_ready) begin
                    hs_c    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Vertex latch, settle counter, triangle registers and delivery counter
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            settle_q <= '0;
            vtx_x_q  <= '0;
            vtx_y_q  <= '0;
            tri0_x_q <= '0;
            tri0_y_q <= '0;
            tri1_x_q <= '0;
            tri1_y_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept_c) begin
                vtx_x_q <= bus.in_x;
                vtx_y_q <= bus.in_y;
            end

            if (accept_c && bus.in_is_quad) begin
                settle_q <= CNT_W'(BREAK_LAT);
            end else if (dec_c) begin
                settle_q <= settle_q - CNT_W'(1);
            end

            // A plain triangle bypasses the breaker and is issued from tri1
            if (accept_c && !bus.in_is_quad) begin
                tri1_x_q <= bus.in_x[TRI_W-1:0];
                tri1_y_q <= bus.in_y[TRI_W-1:0];
            end else if (capture_c) begin
                tri0_x_q <= bus.brk_t0_x;
                tri0_y_q <= bus.brk_t0_y;
                tri1_x_q <= bus.brk_t1_x;
                tri1_y_q <= bus.brk_t1_y;
            end

            if (hs_c) begin
                count_q <= count_q + TCNT_W'(1);
            end
        end
    end

    // Outputs decode only registered state, so they hold steady through a stall
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.tri_valid = (state_q == EMIT0) || (state_q == EMIT1);
    assign bus.tri_last  = (state_q == EMIT1);
    assign bus.tri_x     = (state_q == EMIT0) ? tri0_x_q : tri1_x_q;
    assign bus.tri_y     = (state_q == EMIT0) ? tri0_y_q : tri1_y_q;
    assign bus.brk_x     = vtx_x_q;
    assign bus.brk_y     = vtx_y_q;
    assign bus.tri_count = count_q;

endmodule

// File: tb/tb_poly_sequencer.sv
// tb_poly_sequencer: directed, table-driven bench for poly_sequencer with a
// simple breaker model (T0 = v0,v1,v2 ; T1 = v1,v3,v2).
module tb_poly_sequencer;
    localparam int unsigned BREAK_LAT = 2;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    poly_sequencer_if bus ();

    poly_sequencer #(.BREAK_LAT(BREAK_LAT)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    // Breaker model; perturb lets the bench disturb its outputs at will
    logic [47:0] perturb;
    assign bus.brk_t0_x = bus.brk_x[47:0] ^ perturb;
    assign bus.brk_t0_y = bus.brk_y[47:0] ^ perturb;
    assign bus.brk_t1_x = {bus.brk_x[47:32], bus.brk_x[63:48], bus.brk_x[31:16]} ^ perturb;
    assign bus.brk_t1_y = {bus.brk_y[47:32], bus.brk_y[63:48], bus.brk_y[31:16]} ^ perturb;

    typedef struct {
        logic        is_quad;
        logic [63:0] in_x;
        logic [63:0] in_y;
        logic [47:0] t0_x;
        logic [47:0] t0_y;
        logic [47:0] t1_x;
        logic [47:0] t1_y;
    } vec_t;

    vec_t        vecs [4];
    int          n_err = 0;
    int          n_chk = 0;
    logic [15:0] exp_count;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One primitive with tri_ready held high, checking exact cycle timing
    task automatic run_vec(input vec_t v);
        bus.in_valid   = 1'b1;
        bus.in_is_quad = v.is_quad;
        bus.in_x       = v.in_x;
        bus.in_y       = v.in_y;
        bus.tri_ready  = 1'b1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("brk_x_latch", bus.brk_x, v.in_x);
        chk("brk_y_latch", bus.brk_y, v.in_y);
        if (v.is_quad) begin
            for (int c = 1; c <= int'(BREAK_LAT) + 1; c++) begin
                chk("break_no_valid", 64'(bus.tri_valid), 64'd0);
                chk("break_in_ready", 64'(bus.in_ready), 64'd0);
                tick();
            end
            chk("t0_valid", 64'(bus.tri_valid), 64'd1);
            chk("t0_last", 64'(bus.tri_last), 64'd0);
            chk("t0_x", 64'(bus.tri_x), 64'(v.t0_x));
            chk("t0_y", 64'(bus.tri_y), 64'(v.t0_y));
            chk("t0_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            exp_count = exp_count + 16'd1;
        end
        chk("t1_valid", 64'(bus.tri_valid), 64'd1);
        chk("t1_last", 64'(bus.tri_last), 64'd1);
        chk("t1_x", 64'(bus.tri_x), 64'(v.t1_x));
        chk("t1_y", 64'(bus.tri_y), 64'(v.t1_y));
        chk("t1_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        exp_count = exp_count + 16'd1;
        chk("done_in_ready", 64'(bus.in_ready), 64'd1);
        chk("done_no_valid", 64'(bus.tri_valid), 64'd0);
        chk("tri_count", 64'(bus.tri_count), 64'(exp_count));
    endtask

    logic [47:0] exp_x [4];
    logic [47:0] exp_y [4];
    logic        exp_l [4];

    initial begin
        // triangle (0,0),(10,0),(0,10)
        vecs[0] = '{1'b0, 64'h0000_0000_000A_0000, 64'h0000_000A_0000_0000,
                    48'h0, 48'h0, 48'h0000_000A_0000, 48'h000A_0000_0000};
        // quad (0,0),(10,0),(0,10),(10,10)
        vecs[1] = '{1'b1, 64'h000A_0000_000A_0000, 64'h000A_000A_0000_0000,
                    48'h0000_000A_0000, 48'h000A_0000_0000,
                    48'h0000_000A_000A, 48'h000A_000A_0000};
        // triangle with junk in vertex 3
        vecs[2] = '{1'b0, 64'hDEAD_0300_0200_0100, 64'hBEEF_0030_0020_0010,
                    48'h0, 48'h0, 48'h0300_0200_0100, 48'h0030_0020_0010};
        // quad with extreme coordinates
        vecs[3] = '{1'b1, 64'hABCD_1234_0000_FFFF, 64'hEF01_5678_FFFF_0000,
                    48'h1234_0000_FFFF, 48'h5678_FFFF_0000,
                    48'h1234_ABCD_0000, 48'h5678_EF01_FFFF};

        // Reset with stimulus active
        perturb        = '0;
        rst_l          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_is_quad = 1'b1;
        bus.in_x       = 64'h1234_5678_9ABC_DEF0;
        bus.in_y       = 64'h0FED_CBA9_8765_4321;
        bus.tri_ready  = 1'b1;
        exp_count      = 16'd0;
        repeat (3) tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_tri_valid", 64'(bus.tri_valid), 64'd0);
        chk("rst_tri_last", 64'(bus.tri_last), 64'd0);
        chk("rst_tri_x", 64'(bus.tri_x), 64'd0);
        chk("rst_tri_y", 64'(bus.tri_y), 64'd0);
        chk("rst_brk_x", bus.brk_x, 64'd0);
        chk("rst_brk_y", bus.brk_y, 64'd0);
        chk("rst_tri_count", 64'(bus.tri_count), 64'd0);
        bus.in_valid = 1'b0;
        rst_l        = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_tri_valid", 64'(bus.tri_valid), 64'd0);

        // Table-driven primitives
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Quad stalled 5 cycles in EMIT0, breaker perturbed, competing command offered
        bus.in_valid   = 1'b1;
        bus.in_is_quad = vecs[1].is_quad;
        bus.in_x       = vecs[1].in_x;
        bus.in_y       = vecs[1].in_y;
        bus.tri_ready  = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (BREAK_LAT + 1) tick();
        for (int k = 0; k < 5; k++) begin
            perturb        = 48'({$urandom(), $urandom()}) | 48'd1;
            bus.in_valid   = 1'b1;
            bus.in_is_quad = 1'b0;
            bus.in_x       = 64'h5555_6666_7777_8888;
            bus.in_y       = 64'h1111_2222_3333_4444;
            chk("stall_valid", 64'(bus.tri_valid), 64'd1);
            chk("stall_last", 64'(bus.tri_last), 64'd0);
            chk("stall_x", 64'(bus.tri_x), 64'(vecs[1].t0_x));
            chk("stall_y", 64'(bus.tri_y), 64'(vecs[1].t0_y));
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_brk_x", bus.brk_x, vecs[1].in_x);
            tick();
        end
        bus.tri_ready = 1'b1;
        chk("stall_end_x", 64'(bus.tri_x), 64'(vecs[1].t0_x));
        tick();
        exp_count    = exp_count + 16'd1;
        bus.in_valid = 1'b0;
        chk("stall_t1_last", 64'(bus.tri_last), 64'd1);
        chk("stall_t1_x", 64'(bus.tri_x), 64'(vecs[1].t1_x));
        chk("stall_t1_y", 64'(bus.tri_y), 64'(vecs[1].t1_y));
        chk("stall_t1_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        exp_count = exp_count + 16'd1;
        perturb   = '0;
        chk("stall_done_in_ready", 64'(bus.in_ready), 64'd1);
        chk("stall_done_valid", 64'(bus.tri_valid), 64'd0);
        chk("stall_done_brk_x", bus.brk_x, vecs[1].in_x);
        chk("stall_done_count", 64'(bus.tri_count), 64'(exp_count));

        // Back-to-back T, Q, T with random tri_ready
        exp_x[0] = vecs[0].t1_x; exp_y[0] = vecs[0].t1_y; exp_l[0] = 1'b1;
        exp_x[1] = vecs[1].t0_x; exp_y[1] = vecs[1].t0_y; exp_l[1] = 1'b0;
        exp_x[2] = vecs[1].t1_x; exp_y[2] = vecs[1].t1_y; exp_l[2] = 1'b1;
        exp_x[3] = vecs[2].t1_x; exp_y[3] = vecs[2].t1_y; exp_l[3] = 1'b1;
        begin
            int          in_idx;
            int          out_idx;
            logic        have_prev;
            logic        acc;
            logic        hs;
            logic [47:0] px;
            logic [47:0] py;
            logic        pl;
            in_idx    = 0;
            out_idx   = 0;
            have_prev = 1'b0;
            px = '0; py = '0; pl = 1'b0;
            for (int cyc = 0; cyc < 200 && out_idx < 4; cyc++) begin
                if (have_prev) begin
                    chk("b2b_hold_valid", 64'(bus.tri_valid), 64'd1);
                    chk("b2b_hold_x", 64'(bus.tri_x), 64'(px));
                    chk("b2b_hold_y", 64'(bus.tri_y), 64'(py));
                    chk("b2b_hold_last", 64'(bus.tri_last), 64'(pl));
                end
                if (in_idx < 3) begin
                    bus.in_valid   = 1'b1;
                    bus.in_is_quad = vecs[in_idx].is_quad;
                    bus.in_x       = vecs[in_idx].in_x;
                    bus.in_y       = vecs[in_idx].in_y;
                end else begin
                    bus.in_valid = 1'b0;
                end
                bus.tri_ready = 1'($urandom_range(0, 1));
                acc       = bus.in_ready && bus.in_valid;
                hs        = bus.tri_valid && bus.tri_ready;
                have_prev = bus.tri_valid && !bus.tri_ready;
                px = bus.tri_x; py = bus.tri_y; pl = bus.tri_last;
                if (hs) begin
                    chk("b2b_order_x", 64'(bus.tri_x), 64'(exp_x[out_idx]));
                    chk("b2b_order_y", 64'(bus.tri_y), 64'(exp_y[out_idx]));
                    chk("b2b_last", 64'(bus.tri_last), 64'(exp_l[out_idx]));
                    out_idx++;
                    exp_count = exp_count + 16'd1;
                end
                tick();
                if (acc) in_idx++;
            end
            n_chk++;
            if (out_idx < 4) begin
                n_err++;
                $display("FAIL b2b_timeout: got %0d triangles expected 4", out_idx);
            end
            bus.in_valid = 1'b0;
            chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
            chk("b2b_count", 64'(bus.tri_count), 64'(exp_count));
        end

        // Counter wrap: preset near the top, then deliver two triangles
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFE;
        run_vec(vecs[0]);
        run_vec(vecs[2]);
        chk("wrap_zero", 64'(bus.tri_count), 64'd0);

        // Reset pulsed mid-EMIT0
        bus.in_valid   = 1'b1;
        bus.in_is_quad = vecs[3].is_quad;
        bus.in_x       = vecs[3].in_x;
        bus.in_y       = vecs[3].in_y;
        bus.tri_ready  = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (BREAK_LAT + 1) tick();
        chk("pre_rst_valid", 64'(bus.tri_valid), 64'd1);
        #3;
        rst_l = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.tri_valid), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_rst_count", 64'(bus.tri_count), 64'd0);
        chk("async_rst_brk_x", bus.brk_x, 64'd0);
        chk("async_rst_last", 64'(bus.tri_last), 64'd0);
        exp_count = 16'd0;
        tick();
        rst_l = 1'b1;
        tick();
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/poly_sequencer.md
# poly_sequencer

Control block in front of the GPU rasterizer that owns the quad-splitting datapath. It accepts one primitive command at a time (triangle or 4-vertex quad) over a valid/ready handshake. For quads it holds the vertices steady on the combinational breaker inputs, waits a fixed settle time, and captures the two resulting triangles. It then issues triangles one at a time to the rasterizer over a second valid/ready handshake, marking the last triangle of each primitive.

## Interface
- BREAK_LAT, 2: extra cycles the breaker inputs are held before its outputs are captured. This covers the breaker's multiply/divide path. Legal range 0..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command. Equal to (state == IDLE).
- in_is_quad  in  1  1 = quad (vertices 0..3); 0 = triangle (vertices 0..2; vertex 3 ignored).
- in_x, in_y  in  64 each  vertex n in bits [16n+15:16n], unsigned 16-bit.
- brk_x, brk_y  out  64 each  latched quad vertices driven to the breaker. They hold their value from accept until the next accept.
- brk_t0_x, brk_t0_y  in  48 each  breaker triangle 0, vertex n in bits [16n+15:16n].
- brk_t1_x, brk_t1_y  in  48 each  breaker triangle 1, same packing.
- tri_valid  out  1  triangle offered to the rasterizer.
- tri_ready  in  1  rasterizer accepts the triangle.
- tri_x, tri_y  out  48 each  offered triangle, same packing.
- tri_last  out  1  offered triangle is the final one of its primitive.
- tri_count  out  16  triangles delivered since reset; wraps at 0xFFFF -> 0.

## Operation
- States: IDLE, BREAK, EMIT0, EMIT1. Encoding is free.
- IDLE: in_ready=1.
  - On in_valid & in_ready, latch in_x/in_y into the vertex registers (drives brk_x/brk_y) and latch in_is_quad.
  - Quad: load settle counter with BREAK_LAT and go to BREAK.
  - Triangle: copy vertices 0..2 into tri1 register and go to EMIT1.
- BREAK: counter == 0 -> capture brk_t0_* into tri0 register and brk_t1_* into tri1 register, then go to EMIT0. Otherwise decrement. in_ready=0, tri_valid=0.
- EMIT0: tri_valid=1, tri_x/y=tri0, tri_last=0. On tri_ready go to EMIT1.
- EMIT1: tri_valid=1, tri_x/y=tri1, tri_last=1. On tri_ready go to IDLE.
- tri_x/tri_y/tri_last are registered or derived only from registers. They must not change while tri_valid=1 and tri_ready=0.
- tri_valid never drops without a tri_ready handshake.
- tri_count increments by 1 on every tri_valid & tri_ready cycle, with modulo-2^16 wrap.
- The breaker's outputs are sampled only at the BREAK-exit edge. Changes on brk_t* at any other time have no effect.
- No command is ever dropped or reordered. At most one primitive is in flight.

## Timing
- Reset (rst_l low, asynchronous): state=IDLE, in_ready=1, tri_valid=0, tri_last=0, tri_x/tri_y=0, brk_x/brk_y=0, tri_count=0, settle counter=0.
- Let cycle 0 be the accept edge.
  - Triangle: tri_valid=1 from cycle 1.
  - Quad: BREAK occupies cycles 1..BREAK_LAT+1, and tri_valid=1 from cycle BREAK_LAT+2. This is 4 cycles with the default.
- With tri_ready held high:
  - Quad occupancy is BREAK_LAT+3 cycles and the next accept is possible at cycle BREAK_LAT+4.
  - Triangle occupancy is 1 cycle and the next accept is possible at cycle 2.
- in_ready is low in the cycle tri_valid first rises and stays low until the EMIT1 handshake. There is no same-cycle accept on the final handshake edge.
- tri_ready while tri_valid=0 is ignored. in_valid while in_ready=0 is ignored; upstream holds it.
- Reset asserted mid-primitive aborts it immediately. In-flight triangles are discarded and tri_count clears.

## Test plan
- Reset with stimulus active -> all outputs at reset values; after release in_ready=1 and tri_valid=0.
- Triangle (0,0),(10,0),(0,10), tri_ready=1 -> tri_valid at cycle 1 with tri_x=0x0000_000A_0000 and tri_last=1; tri_count=1; in_ready=1 at cycle 2.
- Quad (0,0),(10,0),(0,10),(10,10), BREAK_LAT=2, model breaker returning T0/T1 -> no tri_valid in cycles 1..3. Cycle 4 delivers T0 with tri_last=0; cycle 5 delivers T1 with tri_last=1; tri_count=2.
- Quad with tri_ready low for 5 cycles in EMIT0 -> tri_x/y/last stable throughout; breaker outputs perturbed during the stall do not alter T0 or T1; in_valid offered during the stall is not accepted.
- Back-to-back triangle, quad, triangle with in_valid always high and tri_ready random -> exact order T, Q0, Q1, T; tri_last pattern 1,0,1,1.
- tri_count preset by 65535 triangles, then one more -> tri_count reads 0. Separately, rst_l pulsed low during EMIT0 -> tri_valid drops asynchronously and the next command is processed normally.
